// File: rtl/fp_add_8_23_f300_uid2.sv
// rtl/fp_add_8_23_f300_uid2.sv - FloPoCo-format binary32 adder, fully pipelined, 7-cycle latency
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset, clears every pipeline register
//   X, Y   [33:0]   operands {exn[1:0], sign, exp[7:0] (bias 127), frac[22:0]}
//                   exn: 00 zero, 01 normal, 10 infinity, 11 NaN
//   R      [33:0]   X + Y in the same format, round-to-nearest ties-to-even
//   ivalid, ovalid  present only when FPADD_VALID_EN is defined; ovalid is ivalid
//                   delayed alongside the data, the datapath ignores it
//
// Pipeline (one register level per edge, inputs captured at edge N, R updated at edge N+7):
//   input capture -> classify/swap -> align -> add/sub -> normalise -> round/pack -> delay -> R

module fp_add_8_23_f300_uid2 (
    input  logic        clk,
    input  logic        rst_n,
`ifdef FPADD_VALID_EN
    input  logic        ivalid,
    output logic        ovalid,
`endif
    input  logic [33:0] X,
    input  logic [33:0] Y,
    output logic [33:0] R
);

    typedef struct packed {
        logic        arith;   // both operands normal: result comes from the datapath
        logic        sign;    // sign of the larger-magnitude operand
        logic [33:0] spec;    // finished result when arith is 0
    } ctl_t;

    // Stage 0: input capture
    logic [33:0] x_q, y_q;

    // Stage 1: classification, magnitude swap
    ctl_t        ctl1_d, ctl1_q;
    logic [7:0]  exp1_d, exp1_q, ediff1_d, ediff1_q;
    logic [23:0] bsig1_d, bsig1_q, ssig1_d, ssig1_q;
    logic        sub1_d, sub1_q;

    // Stage 2: aligned significands, 24 bits + guard/round/sticky
    ctl_t        ctl2_q;
    logic [7:0]  exp2_q;
    logic [26:0] bal2_d, bal2_q, sal2_d, sal2_q;
    logic        sub2_q;

    // Stage 3: raw sum with carry-out bit
    ctl_t        ctl3_q;
    logic [7:0]  exp3_q;
    logic [27:0] sum3_d, sum3_q;

    // Stage 4: normalised significand, signed exponent
    ctl_t               ctl4_q;
    logic signed [9:0]  exp4_d, exp4_q;
    logic [26:0]        norm4_d, norm4_q;
    logic               zero4_d, zero4_q;

    // Stages 5..7: packed result and output delay
    logic [33:0] res5_d, res5_q, res6_q, r_q;

    logic        swap;
    logic [7:0]  small_e;
    logic [1:0]  xe, ye;

    assign xe = x_q[33:32];
    assign ye = y_q[33:32];

    // Stage 1 logic: order operands by {exponent, fraction} and resolve every
    // case that does not need the adder into a finished result.
    always_comb begin
        swap        = (y_q[30:0] > x_q[30:0]);
        small_e     = swap ? x_q[30:23] : y_q[30:23];
        exp1_d      = swap ? y_q[30:23] : x_q[30:23];
        ediff1_d    = exp1_d - small_e;
        bsig1_d     = {1'b1, swap ? y_q[22:0] : x_q[22:0]};
        ssig1_d     = {1'b1, swap ? x_q[22:0] : y_q[22:0]};
        sub1_d      = x_q[31] ^ y_q[31];
        ctl1_d      = '0;
        ctl1_d.sign = swap ? y_q[31] : x_q[31];
        if (xe == 2'b11 || ye == 2'b11 || (xe == 2'b10 && ye == 2'b10 && x_q[31] != y_q[31]))
            ctl1_d.spec = {2'b11, 32'd0};
        else if (xe == 2'b10)
            ctl1_d.spec = {2'b10, x_q[31], 31'd0};
        else if (ye == 2'b10)
            ctl1_d.spec = {2'b10, y_q[31], 31'd0};
        else if (xe == 2'b00 && ye == 2'b00)
            ctl1_d.spec = {2'b00, x_q[31] & y_q[31], 31'd0};
        else if (xe == 2'b00)
            ctl1_d.spec = y_q;
        else if (ye == 2'b00)
            ctl1_d.spec = x_q;
        else
            ctl1_d.arith = 1'b1;
    end

    // Stage 2 logic: right-shift the smaller significand. Bits falling below the
    // round position are OR-ed into sticky; at 26+ only the sticky bit survives.
    logic [49:0] sh2;
    always_comb begin
        sh2    = {ssig1_q, 26'd0} >> ediff1_q;
        bal2_d = {bsig1_q, 3'b000};
        if (ediff1_q >= 8'd26)
            sal2_d = 27'd1;
        else
            sal2_d = {sh2[49:24], |sh2[23:0]};
    end

    // Stage 3 logic: the larger magnitude is first, so subtraction never goes negative.
    always_comb begin
        if (sub2_q)
            sum3_d = {1'b0, bal2_q} - {1'b0, sal2_q};
        else
            sum3_d = {1'b0, bal2_q} + {1'b0, sal2_q};
    end

    // Stage 4 logic: leading-zero count and normalisation shift.
    logic [4:0] lz;
    logic       found;
    always_comb begin
        lz    = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (sum3_q[i])
                    found = 1'b1;
                else
                    lz = lz + 5'd1;
            end
        end
        zero4_d = (sum3_q == 28'd0);
        if (sum3_q[27]) begin
            // Carry-out: one-bit right shift, the dropped bit folds into sticky.
            norm4_d = {sum3_q[27:2], sum3_q[1] | sum3_q[0]};
            exp4_d  = $signed({2'b00, exp3_q}) + 10'sd1;
        end else begin
            norm4_d = sum3_q[26:0] << lz;
            exp4_d  = $signed({2'b00, exp3_q}) - $signed({5'd0, lz});
        end
    end

    // Stage 5 logic: round to nearest even, renormalise on rounding carry, pack.
    logic              rnd_inc;
    logic [24:0]       mant_r;
    logic [22:0]       frac_f;
    logic signed [9:0] exp_f;
    always_comb begin
        rnd_inc = norm4_q[2] & (norm4_q[1] | norm4_q[0] | norm4_q[3]);
        mant_r  = {1'b0, norm4_q[26:3]} + {24'd0, rnd_inc};
        exp_f   = exp4_q + (mant_r[24] ? 10'sd1 : 10'sd0);
        frac_f  = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        if (!ctl4_q.arith)
            res5_d = ctl4_q.spec;
        else if (zero4_q)
            res5_d = 34'd0;
        else if (exp_f >= 10'sd255)
            res5_d = {2'b10, ctl4_q.sign, 31'd0};
        else if (exp_f <= 10'sd0)
            res5_d = {2'b00, ctl4_q.sign, 31'd0};
        else
            res5_d = {2'b01, ctl4_q.sign, exp_f[7:0], frac_f};
    end

    // An all-zero pipeline decodes to arith=0, spec=0, so R reads +zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            ctl1_q   <= '0;
            exp1_q   <= '0;
            ediff1_q <= '0;
            bsig1_q  <= '0;
            ssig1_q  <= '0;
            sub1_q   <= '0;
            ctl2_q   <= '0;
            exp2_q   <= '0;
            bal2_q   <= '0;
            sal2_q   <= '0;
            sub2_q   <= '0;
            ctl3_q   <= '0;
            exp3_q   <= '0;
            sum3_q   <= '0;
            ctl4_q   <= '0;
            exp4_q   <= '0;
            norm4_q  <= '0;
            zero4_q  <= '0;
            res5_q   <= '0;
            res6_q   <= '0;
            r_q      <= '0;
        end else begin
            x_q      <= X;
            y_q      <= Y;
            ctl1_q   <= ctl1_d;
            exp1_q   <= exp1_d;
            ediff1_q <= ediff1_d;
            bsig1_q  <= bsig1_d;
            ssig1_q  <= ssig1_d;
            sub1_q   <= sub1_d;
            ctl2_q   <= ctl1_q;
            exp2_q   <= exp1_q;
            bal2_q   <= bal2_d;
            sal2_q   <= sal2_d;
            sub2_q   <= sub1_q;
            ctl3_q   <= ctl2_q;
            exp3_q   <= exp2_q;
            sum3_q   <= sum3_d;
            ctl4_q   <= ctl3_q;
            exp4_q   <= exp4_d;
            norm4_q  <= norm4_d;
            zero4_q  <= zero4_d;
            res5_q   <= res5_d;
            res6_q   <= res5_q;
            r_q      <= res6_q;
        end
    end

    assign R = r_q;

`ifdef FPADD_VALID_EN
    // Same register depth as the data path so ovalid lines up with R.
    logic [7:0] vld_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_q <= '0;
        else
            vld_q <= {vld_q[6:0], ivalid};
    end
    assign ovalid = vld_q[7];
`endif

endmodule

// File: tb/tb_fp_add_8_23_f300_uid2.sv
// tb/tb_fp_add_8_23_f300_uid2.sv - scoreboard bench for fp_add_8_23_f300_uid2
module tb_fp_add_8_23_f300_uid2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [33:0] X, Y, R;
`ifdef FPADD_VALID_EN
    logic        ivalid, ovalid;
`endif

    always #5 clk = ~clk;

    fp_add_8_23_f300_uid2 dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef FPADD_VALID_EN
        .ivalid (ivalid),
        .ovalid (ovalid),
`endif
        .X      (X),
        .Y      (Y),
        .R      (R)
    );

    typedef struct {
        logic [33:0] r;
        logic        v;
        int          due;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: operand values as doubles (exact), double sum, then one
    // round-to-nearest-even to 24 bits. 53 >= 2*24+2 makes the double rounding exact.
    function automatic real to_real(input logic [33:0] v);
        logic [10:0] de;
        de = 11'(896 + int'(v[30:23]));
        return $bitstoreal({v[31], de, v[22:0], 29'd0});
    endfunction

    function automatic logic [33:0] to_fp(input real s);
        logic [63:0] bits;
        int          e;
        logic [23:0] keep;
        logic [28:0] rem;
        if (s == 0.0) return 34'h0;
        bits = $realtobits(s);
        e    = int'(bits[62:52]) - 1023 + 127;
        keep = {1'b0, bits[51:29]};
        rem  = bits[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0])) keep = keep + 24'd1;
        if (keep[23]) begin
            e    = e + 1;
            keep = 24'd0;
        end
        if (e >= 255) return {2'b10, bits[63], 31'd0};
        if (e <= 0)   return {2'b00, bits[63], 31'd0};
        return {2'b01, bits[63], e[7:0], keep[22:0]};
    endfunction

    function automatic logic [33:0] model(input logic [33:0] a, input logic [33:0] b);
        logic [1:0] ea, eb;
        ea = a[33:32];
        eb = b[33:32];
        if (ea == 2'b11 || eb == 2'b11) return {2'b11, 32'd0};
        if (ea == 2'b10 && eb == 2'b10)
            return (a[31] == b[31]) ? {2'b10, a[31], 31'd0} : {2'b11, 32'd0};
        if (ea == 2'b10) return {2'b10, a[31], 31'd0};
        if (eb == 2'b10) return {2'b10, b[31], 31'd0};
        if (ea == 2'b00 && eb == 2'b00) return {2'b00, a[31] & b[31], 31'd0};
        if (ea == 2'b00) return b;
        if (eb == 2'b00) return a;
        return to_fp(to_real(a) + to_real(b));
    endfunction

    function automatic logic [33:0] rnd_op();
        logic [33:0] v;
        int          r;
        v = {2'b01, 32'($urandom)};
        r = int'($urandom_range(0, 15));
        if (r == 11 || r == 12)      v[33:32] = 2'b00;
        else if (r == 13 || r == 14) v[33:32] = 2'b10;
        else if (r == 15)            v[33:32] = 2'b11;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: R=%h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Every sampling edge with rst_n high gets an expectation, so R must be
    // zero whenever nothing is due (in reset and while reset state drains out).
    task automatic drive(input logic [33:0] a, input logic [33:0] b, input logic [33:0] e,
                         input string nm);
        exp_t t;
        X     = a;
        Y     = b;
        t.r   = e;
        t.v   = 1'b0;
        t.due = cyc + 8;
        t.nm  = nm;
`ifdef FPADD_VALID_EN
        ivalid = 1'($urandom_range(0, 1));
        t.v    = ivalid;
`endif
        sb.push_back(t);
    endtask

    task automatic step(input logic [33:0] a, input logic [33:0] b, input logic [33:0] e,
                        input string nm);
        @(negedge clk);
        #1;
        drive(a, b, e, nm);
    endtask

    task automatic release_with(input logic [33:0] a, input logic [33:0] b, input logic [33:0] e,
                                input string nm);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive(a, b, e, nm);
    endtask

    // Monitor
    initial begin
        exp_t t;
        forever begin
            @(negedge clk);
            if (sb.size() != 0 && sb[0].due == cyc) begin
                t = sb.pop_front();
                chk(t.nm, R, t.r);
`ifdef FPADD_VALID_EN
                checks++;
                if (ovalid !== t.v) begin
                    errors++;
                    $display("FAIL ovalid_%s: ovalid=%b expected %b", t.nm, ovalid, t.v);
                end
`endif
            end else begin
                chk("idle_zero", R, 34'h0);
`ifdef FPADD_VALID_EN
                checks++;
                if (ovalid !== 1'b0) begin
                    errors++;
                    $display("FAIL ovalid_idle: ovalid=%b expected 0", ovalid);
                end
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog");
    end

    localparam logic [33:0] V414 = {2'b01, 32'h40847AE1};
    localparam logic [33:0] ONE  = {2'b01, 32'h3F800000};

    initial begin
        logic [33:0] a, b, xs;
        int          sel;
        rst_n = 1'b0;
        X     = '0;
        Y     = '0;
`ifdef FPADD_VALID_EN
        ivalid = 1'b0;
`endif
        repeat (4) @(negedge clk);

        release_with(V414, V414, {2'b01, 32'h41047AE1}, "req034");
        for (int i = 0; i < 16; i++) begin
            xs = to_fp(4.14 + real'(i));
            step(xs, xs, to_fp(2.0 * (4.14 + real'(i))), "stream");
        end

        step(ONE, {2'b01, 32'hBF800000}, 34'h0, "cancel");
        step(ONE, {2'b01, 32'h33800000}, ONE, "tie_even");
        step({2'b01, 32'h7F7FFFFF}, {2'b01, 32'h7F7FFFFF}, {2'b10, 32'h0}, "overflow");
        step({2'b10, 32'h0}, {2'b10, 32'h80000000}, {2'b11, 32'h0}, "inf_minus_inf");
        step({2'b10, 32'h80000123}, {2'b01, 32'h40A00000}, {2'b10, 32'h80000000}, "inf_fin");
        step({2'b11, 32'h8ABCDEF0}, ONE, {2'b11, 32'h0}, "nan_in");
        step({2'b00, 32'h00001234}, {2'b01, 32'hC0490FDB}, {2'b01, 32'hC0490FDB}, "zero_plus_y");
        step({2'b00, 32'h80000000}, {2'b00, 32'h80000000}, {2'b00, 32'h80000000}, "zz_neg");
        step({2'b00, 32'h0}, {2'b00, 32'h80000000}, 34'h0, "zz_mixed");
        step({2'b01, 32'h3FFFFFFF}, {2'b01, 32'h33800000}, {2'b01, 32'h40000000}, "round_carry");
        step({2'b01, 32'h0}, {2'b01, 32'h0}, {2'b01, 32'h00800000}, "exp0_normal");
        step(ONE, {2'b01, 32'h32800000}, ONE, "shift26");
        step(ONE, {2'b01, 32'h33C00000}, {2'b01, 32'h3F800001}, "above_half");
        step({2'b01, 32'h00800000}, {2'b01, 32'h80000000}, 34'h0, "underflow");

        for (int n = 0; n < 500; n++) begin
            a   = rnd_op();
            b   = rnd_op();
            sel = int'($urandom_range(0, 7));
            if (sel < 3)       b[30:23] = a[30:23] + 8'($urandom_range(0, 3));
            else if (sel == 3) b = {a[33:32], ~a[31], a[30:0]};
            else if (sel == 4) b = {b[33:32], ~a[31], a[30:23], a[22:0] ^ 23'($urandom_range(0, 7))};
            else if (sel == 5) b[30:23] = a[30:23] - 8'($urandom_range(23, 27));
            step(a, b, model(a, b), "random");
        end

        // Reset mid-stream: everything in flight must vanish.
        for (int n = 0; n < 5; n++) begin
            a = {2'b01, 32'($urandom)};
            step(a, a, model(a, a), "pre_reset");
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("reset_immediate", R, 34'h0);
        repeat (3) @(negedge clk);
        release_with(V414, V414, {2'b01, 32'h41047AE1}, "req040");

        for (int n = 0; n < 10; n++) step(34'h0, 34'h0, 34'h0, "drain");
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
